// File: rtl/word_byte_unpacker.sv
// word_byte_unpacker: splits a WIDTH-bit word into 1..WIDTH/8 bytes on a
// byte stream with valid/ready and a last marker. in_ready is the only
// combinational output; everything else is registered.
module word_byte_unpacker #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned NB_W     = $clog2(WIDTH / 8) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NB_W-1:0]  in_nbytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    localparam int unsigned NBYTES = WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  word_q;
    logic [NB_W-1:0]   nbytes_q;
    logic [NB_W-1:0]   idx_q;
    logic [NB_W-1:0]   idx_next_c;
    logic [NB_W-1:0]   n_eff_c;
    logic              accept_c;
    logic              take_c;

    // Byte for stream position i, honouring the configured byte order.
    function automatic logic [7:0] pick_byte(input logic [WIDTH-1:0] w,
                                             input logic [NB_W-1:0]  i);
        logic [NB_W-1:0]  k;
        logic [WIDTH-1:0] sh;
        k  = LSB_FIRST ? i : (NB_W'(NBYTES - 1) - i);
        sh = w >> (32'(k) << 3);
        return sh[7:0];
    endfunction

    // Effective byte count: zero or oversize requests mean a full word.
    always_comb begin
        n_eff_c = in_nbytes;
        if (in_nbytes == '0 || in_nbytes > NB_W'(NBYTES)) begin
            n_eff_c = NB_W'(NBYTES);
        end
    end

    assign idx_next_c = idx_q + NB_W'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus input-side and output-side handshake strobes.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept_c   = 1'b0;
        take_c     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    accept_c   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    take_c = 1'b1;
                    if (out_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word capture, byte sequencing and the free-running byte counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q     <= '0;
            nbytes_q   <= '0;
            idx_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
        end else if (accept_c) begin
            word_q    <= in_data;
            nbytes_q  <= n_eff_c;
            idx_q     <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= pick_byte(in_data, '0);
            out_last  <= (n_eff_c == NB_W'(1));
        end else if (take_c) begin
            byte_count <= byte_count + CNT_W'(1);
            if (out_last) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                idx_q     <= '0;
            end else begin
                idx_q    <= idx_next_c;
                out_data <= pick_byte(word_q, idx_next_c);
                out_last <= (idx_next_c == (nbytes_q - NB_W'(1)));
            end
        end
    end

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Directed bench for word_byte_unpacker: one LSB-first instance with a
// 16-bit counter and one MSB-first instance with a 3-bit counter so the
// wrap case is reachable in a few words.
module tb_word_byte_unpacker;

    logic        clock;
    logic        reset;
    logic        in_valid_l;
    logic        in_valid_m;
    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, out_last_l, busy_l;
    logic [7:0]  out_data_l;
    logic [15:0] byte_count_l;
    logic        in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]  out_data_m;
    logic [2:0]  byte_count_m;

    int checks = 0;
    int errors = 0;

    word_byte_unpacker #(.WIDTH(32), .LSB_FIRST(1'b1), .CNT_W(16)) dut_lsb (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_l), .in_ready(in_ready_l),
        .in_data(in_data), .in_nbytes(in_nbytes),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_last(out_last_l),
        .busy(busy_l), .byte_count(byte_count_l)
    );

    word_byte_unpacker #(.WIDTH(32), .LSB_FIRST(1'b0), .CNT_W(3)) dut_msb (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_m), .in_ready(in_ready_m),
        .in_data(in_data), .in_nbytes(in_nbytes),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_data(out_data_m), .out_last(out_last_m),
        .busy(busy_m), .byte_count(byte_count_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid_l = 1'b0; in_valid_m = 1'b0;
        in_data = '0; in_nbytes = '0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready_l !== 1'b0 || out_valid_l !== 1'b0 || out_last_l !== 1'b0 ||
            busy_l !== 1'b0 || out_data_l !== 8'h00 || byte_count_l !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b last=%b busy=%b data=%h cnt=%0d expected 0 0 0 0 00 0",
                     in_ready_l, out_valid_l, out_last_l, busy_l, out_data_l, byte_count_l);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready_l, in_ready_m);
        end
    endtask

    task automatic test_lsb_full;
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        in_data = 32'hA1B2C3D4; in_nbytes = 3'd4; in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        in_data = 32'h0BADF00D; in_nbytes = 3'd1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid_l !== 1'b1 || out_data_l !== exp_b[k] ||
                out_last_l !== (k == 3) || busy_l !== 1'b1 || in_ready_l !== 1'b0) begin
                errors++;
                $display("FAIL lsb_full byte%0d: vld=%b data=%h last=%b busy=%b rdy=%b expected 1 %h %b 1 0",
                         k, out_valid_l, out_data_l, out_last_l, busy_l, in_ready_l, exp_b[k], k == 3);
            end
            tick();
        end
        checks++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || busy_l !== 1'b0 || byte_count_l !== 16'd4) begin
            errors++;
            $display("FAIL lsb_full_end: vld=%b rdy=%b busy=%b cnt=%0d expected 0 1 0 4",
                     out_valid_l, in_ready_l, busy_l, byte_count_l);
        end
    endtask

    task automatic test_clamp;
        logic [7:0] exp_b [4];
        logic [2:0] nb_list [2];
        exp_b   = '{8'h88, 8'h77, 8'h66, 8'h55};
        nb_list = '{3'd0, 3'd7};
        for (int w = 0; w < 2; w++) begin
            in_data = 32'h55667788; in_nbytes = nb_list[w]; in_valid_l = 1'b1;
            tick();
            in_valid_l = 1'b0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (out_valid_l !== 1'b1 || out_data_l !== exp_b[k] || out_last_l !== (k == 3)) begin
                    errors++;
                    $display("FAIL clamp nb=%0d byte%0d: vld=%b data=%h last=%b expected 1 %h %b",
                             nb_list[w], k, out_valid_l, out_data_l, out_last_l, exp_b[k], k == 3);
                end
                tick();
            end
        end
        checks++;
        if (byte_count_l !== 16'd12 || out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL clamp_count: cnt=%0d vld=%b expected 12 0", byte_count_l, out_valid_l);
        end
        in_data = 32'h000000FF; in_nbytes = 3'd1; in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1 || out_data_l !== 8'hFF || out_last_l !== 1'b1) begin
            errors++;
            $display("FAIL single_byte: vld=%b data=%h last=%b expected 1 ff 1",
                     out_valid_l, out_data_l, out_last_l);
        end
        tick();
        checks++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || byte_count_l !== 16'd13) begin
            errors++;
            $display("FAIL single_byte_end: vld=%b rdy=%b cnt=%0d expected 0 1 13",
                     out_valid_l, in_ready_l, byte_count_l);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b [4];
        int n;
        int cyc;
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
        n = 0;
        cyc = 0;
        in_data = 32'h11223344; in_nbytes = 3'd4; in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        while (n < 4 && cyc < 20) begin
            out_ready = (cyc % 3 == 0);
            checks++;
            if (out_valid_l !== 1'b1 || out_data_l !== exp_b[n] || out_last_l !== (n == 3)) begin
                errors++;
                $display("FAIL backpressure cyc%0d: vld=%b data=%h last=%b expected 1 %h %b",
                         cyc, out_valid_l, out_data_l, out_last_l, exp_b[n], n == 3);
            end
            if (out_ready) n++;
            cyc++;
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (n != 4 || out_valid_l !== 1'b0 || byte_count_l !== 16'd17) begin
            errors++;
            $display("FAIL backpressure_end: taken=%0d vld=%b cnt=%0d expected 4 0 17",
                     n, out_valid_l, byte_count_l);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_b [4];
        exp_b = '{8'h04, 8'h03, 8'h02, 8'h01};
        in_data = 32'hDEADBEEF; in_nbytes = 3'd4; in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        checks++;
        if (out_data_l !== 8'hEF) begin
            errors++;
            $display("FAIL reset_mid_first: data=%h expected ef", out_data_l);
        end
        tick();
        tick();
        checks++;
        if (out_data_l !== 8'hAD || byte_count_l !== 16'd19) begin
            errors++;
            $display("FAIL reset_mid_third: data=%h cnt=%0d expected ad 19", out_data_l, byte_count_l);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid_l !== 1'b0 || byte_count_l !== 16'd0 || busy_l !== 1'b0 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_clear: vld=%b cnt=%0d busy=%b rdy=%b expected 0 0 0 1",
                     out_valid_l, byte_count_l, busy_l, in_ready_l);
        end
        in_data = 32'h01020304; in_nbytes = 3'd4; in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid_l !== 1'b1 || out_data_l !== exp_b[k] || out_last_l !== (k == 3)) begin
                errors++;
                $display("FAIL reset_mid_new byte%0d: vld=%b data=%h last=%b expected 1 %h %b",
                         k, out_valid_l, out_data_l, out_last_l, exp_b[k], k == 3);
            end
            tick();
        end
        checks++;
        if (byte_count_l !== 16'd4) begin
            errors++;
            $display("FAIL reset_mid_count: cnt=%0d expected 4", byte_count_l);
        end
    endtask

    task automatic test_msb;
        logic [7:0] exp_b [2];
        exp_b = '{8'hA1, 8'hB2};
        in_data = 32'hA1B2C3D4; in_nbytes = 3'd2; in_valid_m = 1'b1;
        tick();
        in_valid_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid_m !== 1'b1 || out_data_m !== exp_b[k] || out_last_m !== (k == 1)) begin
                errors++;
                $display("FAIL msb byte%0d: vld=%b data=%h last=%b expected 1 %h %b",
                         k, out_valid_m, out_data_m, out_last_m, exp_b[k], k == 1);
            end
            tick();
        end
        checks++;
        if (out_valid_m !== 1'b0 || byte_count_m !== 3'd2 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL msb_end: vld=%b cnt=%0d busy=%b expected 0 2 0",
                     out_valid_m, byte_count_m, busy_m);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] words [2];
        logic [7:0]  exp_b [2][4];
        logic [2:0]  exp_cnt [2];
        words   = '{32'hA1B2C3D4, 32'h01020304};
        exp_b   = '{'{8'hA1, 8'hB2, 8'hC3, 8'hD4}, '{8'h01, 8'h02, 8'h03, 8'h04}};
        exp_cnt = '{3'd6, 3'd2};
        for (int w = 0; w < 2; w++) begin
            in_data = words[w]; in_nbytes = 3'd4; in_valid_m = 1'b1;
            tick();
            in_valid_m = 1'b0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (out_valid_m !== 1'b1 || out_data_m !== exp_b[w][k] || out_last_m !== (k == 3)) begin
                    errors++;
                    $display("FAIL wrap w%0d byte%0d: vld=%b data=%h last=%b expected 1 %h %b",
                             w, k, out_valid_m, out_data_m, out_last_m, exp_b[w][k], k == 3);
                end
                tick();
            end
            checks++;
            if (byte_count_m !== exp_cnt[w]) begin
                errors++;
                $display("FAIL wrap_count w%0d: cnt=%0d expected %0d", w, byte_count_m, exp_cnt[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_full();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_msb();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
